// File: rtl/operand_entry.sv
// Four-digit BCD operand entry: sliders auto-repeat digit increments, enter
// commits operand A then B, clear returns to the start from any phase.
module operand_entry_digit (
   input  logic       clk,
   input  logic       clear,
   input  logic       inc,
   output logic [3:0] digit
);
   always_ff @(posedge clk) begin
      if (clear)
         digit <= 4'd0;
      else if (inc)
         digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
   end
endmodule

module operand_entry #(
   parameter int SLIDER_OVERFLOW = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sld_1,
   input  logic        sld_2,
   input  logic        sld_3,
   input  logic        sld_4,
   input  logic        btn_ent,
   input  logic        btn_clr,
   output logic [15:0] entry_bcd,
   output logic [13:0] operand_a,
   output logic [13:0] operand_b,
   output logic        operands_valid,
   output logic [1:0]  phase
);
   localparam int RW = $clog2(SLIDER_OVERFLOW);
   localparam logic [RW-1:0] RPT_MAX = RW'(SLIDER_OVERFLOW - 1);

   localparam logic [1:0] ENTER_A = 2'd0;
   localparam logic [1:0] ENTER_B = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;

   logic [RW-1:0]   rpt;
   logic            ent_q, clr_q;
   logic            ent_edge, clr_edge;
   logic            editing, tick, dig_clear;
   logic [3:0]      sld;
   logic [3:0][3:0] dig;
   logic [13:0]     entry_val;

   assign sld       = {sld_4, sld_3, sld_2, sld_1};
   assign ent_edge  = btn_ent & ~ent_q;
   assign clr_edge  = btn_clr & ~clr_q;
   assign editing   = (phase == ENTER_A) || (phase == ENTER_B);
   assign tick      = editing && (|sld) && (rpt == RPT_MAX);
   // An enter edge latches the pre-increment digits and wipes them, so it
   // also swallows any increment landing in the same cycle.
   assign dig_clear = reset || clr_edge || (editing && ent_edge);
   assign entry_bcd = dig;

   assign entry_val = 14'(dig[3]) * 14'd1000 + 14'(dig[2]) * 14'd100
                    + 14'(dig[1]) * 14'd10   + 14'(dig[0]);

   for (genvar i = 0; i < 4; i++) begin : g_dig
      operand_entry_digit u_dig (
         .clk   (clk),
         .clear (dig_clear),
         .inc   (tick & sld[i]),
         .digit (dig[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase          <= ENTER_A;
         operand_a      <= '0;
         operand_b      <= '0;
         operands_valid <= 1'b0;
         rpt            <= '0;
         ent_q          <= 1'b0;
         clr_q          <= 1'b0;
      end else begin
         ent_q          <= btn_ent;
         clr_q          <= btn_clr;
         operands_valid <= 1'b0;
         if (clr_edge) begin
            operand_a <= '0;
            operand_b <= '0;
            rpt       <= '0;
            phase     <= ENTER_A;
         end else begin
            case (phase)
               ENTER_A, ENTER_B: begin
                  if (ent_edge) begin
                     rpt <= '0;
                     if (phase == ENTER_A) begin
                        operand_a <= entry_val;
                        phase     <= ENTER_B;
                     end else begin
                        operand_b      <= entry_val;
                        operands_valid <= 1'b1;
                        phase          <= DONE;
                     end
                  end else if (!(|sld) || rpt == RPT_MAX)
                     rpt <= '0;
                  else
                     rpt <= rpt + RW'(1);
               end
               DONE:    rpt <= '0;
               default: begin
                  rpt   <= '0;
                  phase <= ENTER_A;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed vector table, corner sequences and a
// randomized run, all checked against a digit/arithmetic reference model.
module tb_operand_entry;
   localparam int P = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sld_1 = 1'b0, sld_2 = 1'b0, sld_3 = 1'b0, sld_4 = 1'b0;
   logic        btn_ent = 1'b0, btn_clr = 1'b0;
   logic [15:0] entry_bcd;
   logic [13:0] operand_a, operand_b;
   logic        operands_valid;
   logic [1:0]  phase;

   operand_entry #(.SLIDER_OVERFLOW(P)) dut (
      .clk(clk), .reset(reset),
      .sld_1(sld_1), .sld_2(sld_2), .sld_3(sld_3), .sld_4(sld_4),
      .btn_ent(btn_ent), .btn_clr(btn_clr),
      .entry_bcd(entry_bcd), .operand_a(operand_a), .operand_b(operand_b),
      .operands_valid(operands_valid), .phase(phase)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: digits as integers, held cycles counted since press
   int m_dig[4];
   int m_held, m_a, m_b, m_ph;
   bit m_vld, m_ent_q, m_clr_q;

   function automatic int m_val();
      return m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
   endfunction

   function automatic logic [15:0] m_bcd();
      return 16'(m_dig[3] * 4096 + m_dig[2] * 256 + m_dig[1] * 16 + m_dig[0]);
   endfunction

   task automatic m_zero_entry();
      for (int i = 0; i < 4; i++) m_dig[i] = 0;
      m_held = 0;
   endtask

   task automatic model_step(input bit rst, input bit [3:0] s, input bit e, input bit c);
      bit ee, ce;
      if (rst) begin
         m_zero_entry();
         m_a = 0; m_b = 0; m_ph = 0; m_vld = 0; m_ent_q = 0; m_clr_q = 0;
      end else begin
         ee = e && !m_ent_q;
         ce = c && !m_clr_q;
         m_ent_q = e;
         m_clr_q = c;
         m_vld = 0;
         if (ce) begin
            m_zero_entry();
            m_a = 0; m_b = 0; m_ph = 0;
         end else if (m_ph == 2) begin
            m_held = 0;
         end else if (ee) begin
            if (m_ph == 0) m_a = m_val();
            else begin m_b = m_val(); m_vld = 1; end
            m_zero_entry();
            m_ph = m_ph + 1;
         end else if (s != 0) begin
            m_held = m_held + 1;
            if (m_held == P) begin
               m_held = 0;
               for (int i = 0; i < 4; i++)
                  if (s[i]) m_dig[i] = (m_dig[i] + 1) % 10;
            end
         end else
            m_held = 0;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic cyc(input bit rst, input bit [3:0] s, input bit e, input bit c);
      @(negedge clk);
      reset = rst;
      {sld_4, sld_3, sld_2, sld_1} = s;
      btn_ent = e;
      btn_clr = c;
      @(posedge clk);
      model_step(rst, s, e, c);
      #1;
      check("bcd", 32'(entry_bcd), 32'(m_bcd()));
      check("op_a", 32'(operand_a), 32'(m_a));
      check("op_b", 32'(operand_b), 32'(m_b));
      check("valid", 32'(operands_valid), 32'(m_vld));
      check("phase", 32'(phase), 32'(m_ph));
   endtask

   typedef struct {
      logic [3:0]  sld;
      int          hold;
      bit          ent;
      bit          clr;
      logic [15:0] bcd;
      int          a;
      int          b;
      int          ph;
   } vec_t;

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{4'b0010, 31, 0, 0, 16'h0000, 0,    0,  0};
      tbl[1]  = '{4'b0001,  7, 0, 0, 16'h0002, 0,    0,  0};
      tbl[2]  = '{4'b0001,  6, 0, 0, 16'h0004, 0,    0,  0};
      tbl[3]  = '{4'b0010,  9, 0, 0, 16'h0034, 0,    0,  0};
      tbl[4]  = '{4'b0100,  6, 0, 0, 16'h0234, 0,    0,  0};
      tbl[5]  = '{4'b1000,  3, 1, 0, 16'h0000, 1234, 0,  1};
      tbl[6]  = '{4'b0010, 15, 0, 0, 16'h0050, 1234, 0,  1};
      tbl[7]  = '{4'b0001, 18, 1, 0, 16'h0000, 1234, 56, 2};
      tbl[8]  = '{4'b1000, 12, 1, 0, 16'h0000, 1234, 56, 2};
      tbl[9]  = '{4'b0000,  0, 0, 1, 16'h0000, 0,    0,  0};
      tbl[10] = '{4'b0001,  3, 1, 0, 16'h0000, 1,    0,  1};
      tbl[11] = '{4'b0001,  3, 1, 1, 16'h0000, 0,    0,  0};
      tbl[12] = '{4'b1111,  6, 0, 0, 16'h2222, 0,    0,  0};
      tbl[13] = '{4'b0000,  0, 1, 0, 16'h0000, 2222, 0,  1};

      cyc(1, 4'b0000, 0, 0);
      cyc(1, 4'b0000, 0, 0);
      check("rst_bcd", 32'(entry_bcd), 32'h0);
      check("rst_phase", 32'(phase), 32'h0);
      check("rst_valid", 32'(operands_valid), 32'h0);

      for (int i = 0; i < 14; i++) begin
         repeat (tbl[i].hold) cyc(0, tbl[i].sld, 0, 0);
         cyc(0, 4'b0000, tbl[i].ent, tbl[i].clr);
         if (i == 7) check("valid_strobe", 32'(operands_valid), 32'h1);
         cyc(0, 4'b0000, 0, 0);
         check("vec_bcd", 32'(entry_bcd), 32'(tbl[i].bcd));
         check("vec_a", 32'(operand_a), 32'(tbl[i].a));
         check("vec_b", 32'(operand_b), 32'(tbl[i].b));
         check("vec_phase", 32'(phase), 32'(tbl[i].ph));
         check("vec_valid", 32'(operands_valid), 32'h0);
      end

      // enter edge on the same cycle as an increment keeps the old digits
      cyc(0, 4'b0000, 0, 1);
      cyc(0, 4'b0000, 0, 0);
      repeat (5) cyc(0, 4'b0001, 0, 0);
      cyc(0, 4'b0001, 1, 0);
      check("coinc_a", 32'(operand_a), 32'd1);
      check("coinc_bcd", 32'(entry_bcd), 32'h0);
      check("coinc_phase", 32'(phase), 32'd1);
      cyc(0, 4'b0000, 0, 0);

      // enter held high commits only once
      cyc(0, 4'b0000, 0, 1);
      cyc(0, 4'b0000, 0, 0);
      repeat (5) cyc(0, 4'b0000, 1, 0);
      check("hold_ent_phase", 32'(phase), 32'd1);
      check("hold_ent_b", 32'(operand_b), 32'd0);
      cyc(0, 4'b0000, 0, 0);

      // reset mid-hold, then the repeat count starts over
      repeat (2) cyc(0, 4'b0100, 0, 0);
      repeat (2) cyc(1, 4'b0100, 0, 0);
      check("rst_hold_bcd", 32'(entry_bcd), 32'h0);
      check("rst_hold_phase", 32'(phase), 32'd0);
      check("rst_hold_a", 32'(operand_a), 32'd0);
      repeat (2) cyc(0, 4'b0100, 0, 0);
      check("post_rst_2", 32'(entry_bcd), 32'h0);
      cyc(0, 4'b0100, 0, 0);
      check("post_rst_3", 32'(entry_bcd), 32'h0100);

      // reset landing on the operands_valid cycle
      cyc(0, 4'b0000, 1, 0);
      cyc(0, 4'b0000, 0, 0);
      cyc(0, 4'b0000, 1, 0);
      check("pre_rst_valid", 32'(operands_valid), 32'h1);
      cyc(1, 4'b0000, 1, 0);
      check("rst_valid_cyc", 32'(operands_valid), 32'h0);
      check("rst_valid_a", 32'(operand_a), 32'd0);

      begin
         bit [3:0] s = 4'b0000;
         for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) s = 4'($urandom_range(0, 15));
            cyc($urandom_range(0, 149) == 0, s,
                $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 SHALL have parameter SLIDER_OVERFLOW, default 50_000_000, the number of clk cycles a held slider waits between digit increments (minimum 2).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sld_1 / sld_2 / sld_3 / sld_4  input  1 each  digit increment sliders for ones / tens / hundreds / thousands.
REQ-005 SHALL have port btn_ent  input  1  debounced enter button, level.
REQ-006 SHALL have port btn_clr  input  1  debounced clear button, level.
REQ-007 SHALL have port entry_bcd  output  16  the digits being edited, packed as thousands[15:12], hundreds[11:8], tens[7:4], ones[3:0].
REQ-008 SHALL have port operand_a  output  14  binary value of the first committed operand.
REQ-009 SHALL have port operand_b  output  14  binary value of the second committed operand.
REQ-010 SHALL have port operands_valid  output  1  one-cycle strobe when both operands have been committed.
REQ-011 SHALL have port phase  output  2  current state: 0=ENTER_A, 1=ENTER_B, 2=DONE.

Function
REQ-012 SHALL detect enter and clear events as rising edges: input high this cycle and low in the previous registered sample.
REQ-013 SHALL keep one shared repeat counter rpt, 0..SLIDER_OVERFLOW-1.
REQ-014 In ENTER_A or ENTER_B with no slider high, rpt SHALL be 0 on the next cycle.
REQ-015 In ENTER_A or ENTER_B with at least one slider high and rpt < SLIDER_OVERFLOW-1, rpt SHALL increment.
REQ-016 In ENTER_A or ENTER_B with at least one slider high and rpt == SLIDER_OVERFLOW-1, rpt SHALL return to 0 and every digit whose slider is high SHALL increment by one in the same cycle.
REQ-017 Each digit SHALL stay in BCD 0..9 and wrap from 9 to 0 without carrying into the next digit.
REQ-018 A continuous hold of N cycles SHALL therefore produce floor(N/SLIDER_OVERFLOW) increments; a release restarts the count.
REQ-019 On an enter edge in ENTER_A: operand_a <= 1000*thousands + 100*hundreds + 10*tens + ones; entry_bcd <= 0; rpt <= 0; phase -> ENTER_B.
REQ-020 On an enter edge in ENTER_B: operand_b is loaded by the same conversion as REQ-019; entry_bcd <= 0; operands_valid is high for exactly the next cycle; phase -> DONE.
REQ-021 In DONE, sliders and enter edges SHALL be ignored, rpt SHALL be held at 0, and entry_bcd, operand_a and operand_b SHALL be held.
REQ-022 On a clear edge in any phase: entry_bcd, operand_a, operand_b and rpt <= 0; phase -> ENTER_A; operands_valid low.
REQ-023 If clear and enter edges fall in the same cycle, clear SHALL win and enter SHALL be discarded.
REQ-024 On an enter edge coinciding with a slider increment, the latch SHALL use the pre-increment digits, and the increment SHALL be discarded.
REQ-025 Holding btn_ent high SHALL commit only once, with no re-trigger until it is released and pressed again.
REQ-026 operand_a and operand_b SHALL be registered and never exceed 9999.

Reset
REQ-027 While reset is high on a clk edge: phase=ENTER_A, entry_bcd=0, operand_a=0, operand_b=0, operands_valid=0, rpt=0, and both edge-detect samples=0.
REQ-028 Reset SHALL override every concurrent slider, enter or clear activity, including a reset asserted mid-hold or in the operands_valid cycle.
REQ-029 The first cycle after reset deasserts SHALL behave as a normal ENTER_A cycle.

Verification (SLIDER_OVERFLOW=3)
REQ-030 Hold sld_1 for 7 cycles -> entry_bcd=16'h0002.
REQ-031 Hold sld_2 for 31 cycles -> tens digit wraps and ends at 0; entry_bcd=16'h0000.
REQ-032 Enter digits 1-2-3-4, then an ent pulse -> operand_a=1234, entry_bcd=0, phase=1.
REQ-033 Enter 0-0-5-6, then an ent pulse -> operand_b=56, operands_valid high exactly 1 cycle, phase=2.
REQ-034 In DONE, hold sld_4 for 12 cycles and press ent again -> all outputs unchanged.
REQ-035 Press btn_clr and btn_ent in the same cycle while in ENTER_B -> phase=0, all operands 0.
REQ-036 Assert reset while sld_3 is held -> all outputs 0 and rpt restarts at 0.
